// File: rtl/alu_control_seq_pkg.sv
// alu_control_seq_pkg
// Shared constants for the MIPS ALU-control stage: ALU operation encodings,
// R-type funct and I-type opcode values, alu_op_type selector values, FSM
// state encodings and the decode result struct.
package alu_control_seq_pkg;

  // ALU operation encodings (4 bits; the top zero-extends to ALU_OP_W)
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MUL  = 4'd12,
    ALU_MULU = 4'd13,
    ALU_DIV  = 4'd14,
    ALU_DIVU = 4'd15
  } alu_op_e;

  // alu_op_type selector
  typedef enum logic [1:0] {
    AT_ADD   = 2'b00,
    AT_SUB   = 2'b01,
    AT_RTYPE = 2'b10,
    AT_ITYPE = 2'b11
  } alu_type_e;

  // R-type funct field values
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // I-type opcode values
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MD_BUSY = 2'd1,
    S_OUT     = 2'd2
  } state_e;

  // Decode result
  typedef struct packed {
    alu_op_e op;
    logic    shift_var;
    logic    is_muldiv;
  } dec_s;

endpackage

// File: rtl/alu_control_seq_decode.sv
// alu_op_decode
// Pure combinational ALU-control decode, usable on its own by a single-cycle
// datapath.
// Ports:
//   alu_op_type [1:0]  00 add, 01 sub, 10 R-type funct, 11 I-type opcode
//   opcode      [5:0]  instruction opcode
//   funct       [5:0]  instruction funct
//   dec                decoded op, shift_var, is_muldiv
//   illegal            (only with ALU_CTRL_ILLEGAL_TRAP_EN) unlisted code seen
// Configuration macro: ALU_CTRL_ILLEGAL_TRAP_EN
module alu_op_decode
  import alu_control_seq_pkg::*;
(
  input  logic [1:0] alu_op_type,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_s       dec
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  alu_op_e op;
  logic    sv;
  logic    md;
  logic    known;

  always_comb begin
    op    = ALU_ADD;
    sv    = 1'b0;
    md    = 1'b0;
    known = 1'b1;
    unique case (alu_type_e'(alu_op_type))
      AT_ADD: op = ALU_ADD;
      AT_SUB: op = ALU_SUB;
      AT_RTYPE: begin
        case (funct)
          F_SLL:           op = ALU_SLL;
          F_SRL:           op = ALU_SRL;
          F_SRA:           op = ALU_SRA;
          F_SLLV:          begin op = ALU_SLL; sv = 1'b1; end
          F_SRLV:          begin op = ALU_SRL; sv = 1'b1; end
          F_SRAV:          begin op = ALU_SRA; sv = 1'b1; end
          F_MULT:          begin op = ALU_MUL;  md = 1'b1; end
          F_MULTU:         begin op = ALU_MULU; md = 1'b1; end
          F_DIV:           begin op = ALU_DIV;  md = 1'b1; end
          F_DIVU:          begin op = ALU_DIVU; md = 1'b1; end
          F_ADD, F_ADDU:   op = ALU_ADD;
          F_SUB, F_SUBU:   op = ALU_SUB;
          F_AND:           op = ALU_AND;
          F_OR:            op = ALU_OR;
          F_XOR:           op = ALU_XOR;
          F_NOR:           op = ALU_NOR;
          F_SLT:           op = ALU_SLT;
          F_SLTU:          op = ALU_SLTU;
          default:         known = 1'b0;
        endcase
      end
      AT_ITYPE: begin
        case (opcode)
          OP_SLTI:  op = ALU_SLT;
          OP_SLTIU: op = ALU_SLTU;
          OP_ANDI:  op = ALU_AND;
          OP_ORI:   op = ALU_OR;
          OP_XORI:  op = ALU_XOR;
          OP_LUI:   op = ALU_LUI;
          default:  known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
  end

  // Unlisted codes always fall back to a plain ADD with no side flags
  assign dec.op        = known ? op : ALU_ADD;
  assign dec.shift_var = known & sv;
  assign dec.is_muldiv = known & md;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal = ~known;
`endif

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq
// Registered, valid/ready ALU-control stage. Decodes on accept and presents
// the result one cycle later; mul/div functs first spend MULDIV_CYCLES cycles
// in a busy window (start pulse in the first cycle, stall throughout).
// Ports:
//   clk, rst                 clock (rising), async active-high reset
//   in_valid / in_ready      request handshake (in_ready from state+out_ready)
//   alu_op_type, opcode, funct  decode inputs
//   out_valid / out_ready    result handshake
//   alu_op [ALU_OP_W-1:0]    decoded op, zero-extended
//   shift_var, is_muldiv     decode flags
//   muldiv_start             one-cycle start pulse to the mul/div unit
//   stall                    high while the mul/div op is in flight
//   illegal_op               (only with ALU_CTRL_ILLEGAL_TRAP_EN)
// Configuration macro: ALU_CTRL_ILLEGAL_TRAP_EN
module alu_control_seq
  import alu_control_seq_pkg::*;
#(
  parameter int ALU_OP_W      = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          alu_op_type,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                shift_var,
  output logic                is_muldiv,
  output logic                muldiv_start,
  output logic                stall
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  state_e     state;
  logic [CNT_W-1:0] cnt;
  dec_s       dec;
  logic       accept;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic dec_illegal;
`endif

  alu_op_decode u_dec (
    .alu_op_type (alu_op_type),
    .opcode      (opcode),
    .funct       (funct),
    .dec         (dec)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal     (dec_illegal)
`endif
  );

  // OUT only frees its slot when the consumer takes the current result
  assign in_ready = (state == S_IDLE) || ((state == S_OUT) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      stall        <= 1'b0;
      muldiv_start <= 1'b0;
      alu_op       <= '0;
      shift_var    <= 1'b0;
      is_muldiv    <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      illegal_op   <= 1'b0;
`endif
    end else begin
      muldiv_start <= 1'b0;
      case (state)
        S_IDLE, S_OUT: begin
          if (accept) begin
            alu_op    <= ALU_OP_W'(dec.op);
            shift_var <= dec.shift_var;
            is_muldiv <= dec.is_muldiv;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_op <= dec_illegal;
`endif
            if (dec.is_muldiv) begin
              state        <= S_MD_BUSY;
              cnt          <= CNT_W'(MULDIV_CYCLES - 1);
              stall        <= 1'b1;
              muldiv_start <= 1'b1;
              out_valid    <= 1'b0;
            end else begin
              state     <= S_OUT;
              out_valid <= 1'b1;
            end
          end else if (state == S_OUT && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_MD_BUSY: begin
          // counter was loaded with N-1, so the window is exactly N cycles
          if (cnt == '0) begin
            state     <= S_OUT;
            stall     <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq
// Scoreboard bench for alu_control_seq: the driver pushes the hand-computed
// expected decode on every accept, a negedge monitor pops and compares on
// every output handshake. Directed sections check mul/div timing, stall
// hold and asynchronous reset.
// Configuration macro: ALU_CTRL_ILLEGAL_TRAP_EN
module tb_alu_control_seq;

  localparam int W  = 4;
  localparam int MC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   alu_op_type = '0;
  logic [5:0]   opcode = '0;
  logic [5:0]   funct = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_op;
  logic         shift_var;
  logic         is_muldiv;
  logic         muldiv_start;
  logic         stall;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic         illegal_op;
`endif

  alu_control_seq #(.ALU_OP_W(W), .MULDIV_CYCLES(MC)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op_type  (alu_op_type),
    .opcode       (opcode),
    .funct        (funct),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_op       (alu_op),
    .shift_var    (shift_var),
    .is_muldiv    (is_muldiv),
    .muldiv_start (muldiv_start),
    .stall        (stall)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] op;
    logic       sv;
    logic       md;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];

  // Monitor: every output handshake must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    logic bad;
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out: got out_valid=1 alu_op=%0d, want no output", alu_op);
      end else begin
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        bad = (alu_op !== W'(e.op)) || (shift_var !== e.sv) || (is_muldiv !== e.md);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        bad = bad || (illegal_op !== e.ill);
`endif
        if (bad) begin
          miscompares++;
          $display("FAIL decode: got op=%0d sv=%0b md=%0b, want op=%0d sv=%0b md=%0b ill=%0b",
                   alu_op, shift_var, is_muldiv, e.op, e.sv, e.md, e.ill);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic send(input logic [1:0] t, input logic [5:0] op, input logic [5:0] fn,
                      input logic [3:0] eop, input logic esv, input logic emd, input logic eill);
    exp_t e;
    alu_op_type = t; opcode = op; funct = fn; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n > 50) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, want 1");
        in_valid = 1'b0;
        return;
      end
    end
    e.op = eop; e.sv = esv; e.md = emd; e.ill = eill;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got no finish, want finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int base;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_start", muldiv_start, 0);
    chk("rst_alu_op", alu_op, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back ADD, SUB, AND with no bubble
    base = pop_cyc.size();
    send(2'b10, 6'h00, 6'h20, 4'd0, 0, 0, 0);
    send(2'b10, 6'h00, 6'h22, 4'd1, 0, 0, 0);
    send(2'b10, 6'h00, 6'h24, 4'd2, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_count", pop_cyc.size() - base, 3);
    if (pop_cyc.size() >= base + 3) begin
      chk("b2b_gap1", pop_cyc[base+1] - pop_cyc[base], 1);
      chk("b2b_gap2", pop_cyc[base+2] - pop_cyc[base+1], 1);
    end

    // Decode table
    send(2'b11, 6'h0F, 6'h00, 4'd11, 0, 0, 0);
    send(2'b11, 6'h0B, 6'h00, 4'd7,  0, 0, 0);
    send(2'b11, 6'h0A, 6'h00, 4'd6,  0, 0, 0);
    send(2'b11, 6'h0C, 6'h00, 4'd2,  0, 0, 0);
    send(2'b11, 6'h0D, 6'h00, 4'd3,  0, 0, 0);
    send(2'b11, 6'h0E, 6'h00, 4'd4,  0, 0, 0);
    send(2'b10, 6'h00, 6'h07, 4'd10, 1, 0, 0);
    send(2'b10, 6'h00, 6'h04, 4'd8,  1, 0, 0);
    send(2'b10, 6'h00, 6'h06, 4'd9,  1, 0, 0);
    send(2'b10, 6'h00, 6'h00, 4'd8,  0, 0, 0);
    send(2'b10, 6'h00, 6'h02, 4'd9,  0, 0, 0);
    send(2'b10, 6'h00, 6'h03, 4'd10, 0, 0, 0);
    send(2'b10, 6'h00, 6'h21, 4'd0,  0, 0, 0);
    send(2'b10, 6'h00, 6'h23, 4'd1,  0, 0, 0);
    send(2'b10, 6'h00, 6'h26, 4'd4,  0, 0, 0);
    send(2'b10, 6'h00, 6'h27, 4'd5,  0, 0, 0);
    send(2'b10, 6'h00, 6'h2A, 4'd6,  0, 0, 0);
    send(2'b10, 6'h00, 6'h2B, 4'd7,  0, 0, 0);
    send(2'b00, 6'h0F, 6'h22, 4'd0,  0, 0, 0);
    send(2'b01, 6'h0F, 6'h2A, 4'd1,  0, 0, 0);
    send(2'b10, 6'h00, 6'h3F, 4'd0,  0, 0, 1);
    send(2'b11, 6'h08, 6'h00, 4'd0,  0, 0, 1);
    send(2'b10, 6'h00, 6'h20, 4'd0,  0, 0, 0);
    send(2'b10, 6'h00, 6'h18, 4'd12, 0, 1, 0);
    send(2'b10, 6'h00, 6'h19, 4'd13, 0, 1, 0);
    send(2'b10, 6'h00, 6'h1B, 4'd15, 0, 1, 0);
    repeat (MC + 4) @(posedge clk);
    #1;

    // DIV timing: accept at cycle 0
    alu_op_type = 2'b10; funct = 6'h1A; in_valid = 1'b1;
    @(negedge clk);
    chk("md_accept_ready", in_ready, 1);
    e.op = 4'd14; e.sv = 1'b0; e.md = 1'b1; e.ill = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= MC; k++) begin
      @(negedge clk);
      chk($sformatf("md_start_c%0d", k), muldiv_start, (k == 1) ? 1 : 0);
      chk($sformatf("md_stall_c%0d", k), stall, 1);
      chk($sformatf("md_in_ready_c%0d", k), in_ready, 0);
      chk($sformatf("md_out_valid_c%0d", k), out_valid, 0);
    end
    @(negedge clk);
    chk("md_out_valid_c5", out_valid, 1);
    chk("md_stall_c5", stall, 0);
    @(posedge clk); #1;

    // Output held while out_ready=0, then next op accepted same cycle
    out_ready = 1'b0;
    send(2'b10, 6'h00, 6'h25, 4'd3, 0, 0, 0);
    alu_op_type = 2'b10; funct = 6'h26; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_alu_op", alu_op, 3);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    e.op = 4'd4; e.sv = 1'b0; e.md = 1'b0; e.ill = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Async reset in cycle 2 of a MULT
    alu_op_type = 2'b10; funct = 6'h18; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_md_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_md_stall_before", stall, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_md_stall", stall, 0);
    chk("rst_md_out_valid", out_valid, 0);
    chk("rst_md_start", muldiv_start, 0);
    chk("rst_md_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (MC + 6) @(posedge clk);
    #1;
    chk("final_out_valid", out_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
